// File: rtl/ntt_batch_memory_ctrl_pkg.sv
// Shared types for the NTT batch memory controller: FSM state encoding and
// the batch-count legality test used when a start is accepted.
package ntt_batch_memory_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // A batch must hold at least one polynomial and no more than 2^logb.
  function automatic logic batch_cfg_ok(input int unsigned bc, input int unsigned logb);
    return (bc != 0) && (bc <= (32'd1 << logb));
  endfunction

endpackage

// File: rtl/ntt_batch_memory_ctrl_addr_counter.sv
// Saturating up-counter with synchronous clear, used for both the source-read
// and destination-write coefficient streams. Count is one bit wider than the address.
module ntt_batch_memory_ctrl_addr_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic [W-2:0] addr_o,
  output logic         at_limit_o,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !at_limit_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign addr_o     = count_q[W-2:0];
  assign at_limit_o = (count_q == limit_i);
  // High in the cycle that performs the final counted step.
  assign last_o     = enable_i && !at_limit_o && ((count_q + 1'b1) == limit_i);

endmodule

// File: rtl/ntt_batch_memory_ctrl.sv
// Streams a batch of polynomials from a source BRAM into the SDF NTT core and
// writes its results back to a destination BRAM, with start/busy/done handshake.
module ntt_batch_memory_ctrl
  import ntt_batch_memory_ctrl_pkg::*;
#(
  parameter int LOGN      = 10,
  parameter int LOGB      = 2,
  parameter int START_DLY = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LOGB:0]        batch_cnt,
  input  logic                 intt_in,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 ntt_start,
  output logic                 ntt_intt,
  input  logic                 ntt_valid,
  output logic                 read_en,
  output logic [LOGN+LOGB-1:0] read_address,
  output logic                 wea,
  output logic [LOGN+LOGB-1:0] write_address
);

  localparam int AW = LOGN + LOGB;
  localparam int CW = AW + 1;
  localparam int DW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  state_e        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [LOGB:0] batch_q;
  logic          intt_q;
  logic          cfg_err_q;
  logic          idle_start, accept, reject;
  logic [CW-1:0] total;
  logic          rd_last, rd_at_limit, wr_last, wr_at_limit;

  assign idle_start = (state_q == ST_IDLE) && start;
  assign accept     = idle_start && batch_cfg_ok(32'(batch_cnt), LOGB);
  assign reject     = idle_start && !batch_cfg_ok(32'(batch_cnt), LOGB);
  assign total      = {batch_q, {LOGN{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DELAY;
      ST_DELAY:  if (dly_q == '0) state_d = ST_STREAM;
      ST_STREAM: if (rd_last || rd_at_limit) state_d = ST_DRAIN;
      ST_DRAIN:  if (wr_last || wr_at_limit) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    read_en   = 1'b0;
    ntt_start = 1'b0;
    case (state_q)
      ST_DELAY, ST_DRAIN: busy = 1'b1;
      ST_STREAM: begin
        busy      = 1'b1;
        read_en   = 1'b1;
        ntt_start = 1'b1;
      end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  // Run-time start delay: loaded on accept so every run sees exactly START_DLY busy cycles.
  always_comb begin
    dly_d = dly_q;
    if (accept) begin
      dly_d = DW'(START_DLY - 1);
    end else if ((state_q == ST_DELAY) && (dly_q != '0)) begin
      dly_d = dly_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q     <= '0;
      batch_q   <= '0;
      intt_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      cfg_err_q <= reject;
      if (accept) begin
        batch_q <= batch_cnt;
        intt_q  <= intt_in;
      end
    end
  end

  assign cfg_err  = cfg_err_q;
  assign ntt_intt = intt_q;
  // Results are accepted whenever a run is active, even before the input stream ends.
  assign wea      = busy && ntt_valid && !wr_at_limit;

  ntt_batch_memory_ctrl_addr_counter #(.W(CW)) u_rd_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .enable_i   (read_en),
    .limit_i    (total),
    .addr_o     (read_address),
    .at_limit_o (rd_at_limit),
    .last_o     (rd_last)
  );

  ntt_batch_memory_ctrl_addr_counter #(.W(CW)) u_wr_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .enable_i   (wea),
    .limit_i    (total),
    .addr_o     (write_address),
    .at_limit_o (wr_at_limit),
    .last_o     (wr_last)
  );

endmodule

// File: tb/tb_ntt_batch_memory_ctrl.sv
// Directed bench for ntt_batch_memory_ctrl with a fixed-latency SDF stand-in
// and a negedge monitor scoring read/write address streams.
module tb_ntt_batch_memory_ctrl;

  localparam int LOGN = 4;
  localparam int LOGB = 2;
  localparam int START_DLY = 3;
  localparam int AW = LOGN + LOGB;
  localparam int LAT = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LOGB:0] batch_cnt = '0;
  logic          intt_in = 1'b0;
  logic          busy, done, cfg_err, ntt_start, ntt_intt, ntt_valid;
  logic          read_en, wea;
  logic [AW-1:0] read_address, write_address;
  logic          inject = 1'b0;
  logic [LAT-1:0] sr;

  ntt_batch_memory_ctrl #(.LOGN(LOGN), .LOGB(LOGB), .START_DLY(START_DLY)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .batch_cnt     (batch_cnt),
    .intt_in       (intt_in),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .ntt_start     (ntt_start),
    .ntt_intt      (ntt_intt),
    .ntt_valid     (ntt_valid),
    .read_en       (read_en),
    .read_address  (read_address),
    .wea           (wea),
    .write_address (write_address)
  );

  always #5 clk = ~clk;

  // SDF stand-in: each streamed coefficient emerges LAT cycles later.
  always @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[LAT-2:0], ntt_start};
  end
  assign ntt_valid = sr[LAT-1] | inject;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int n_rd, n_wr, n_done, n_err, n_busy, n_intt_bad, n_nst_bad;
  int rd_exp, wr_exp, first_rd_cyc, done_cyc;
  logic cur_intt = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_done = 0; n_err = 0; n_busy = 0;
    n_intt_bad = 0; n_nst_bad = 0; rd_exp = 0; wr_exp = 0;
    first_rd_cyc = -1; done_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) n_busy++;
    if (cfg_err === 1'b1) n_err++;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
    end
    if (ntt_start !== read_en) n_nst_bad++;
    if (busy === 1'b1 && ntt_intt !== cur_intt) n_intt_bad++;
    if (read_en === 1'b1) begin
      if (n_rd == 0) first_rd_cyc = cyc;
      check("rd_addr", {26'd0, read_address}, rd_exp % 64);
      n_rd++; rd_exp++;
    end
    if (wea === 1'b1) begin
      check("wr_addr", {26'd0, write_address}, wr_exp % 64);
      n_wr++; wr_exp++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1 || cfg_err === 1'b1) begin seen = 1; break; end
      tick();
    end
    check({tag, "_finished"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_cfg(input int bc, input bit intt, input bit ok, input int total, input string tag);
    int t0;
    clear_mon();
    batch_cnt = (LOGB+1)'(bc); intt_in = intt; cur_intt = intt;
    start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    wait_done(tag);
    repeat (5) tick();
    check({tag, "_reads"}, n_rd, total);
    check({tag, "_writes"}, n_wr, total);
    check({tag, "_done_cnt"}, n_done, {31'd0, ok});
    check({tag, "_cfg_err_cnt"}, n_err, {31'd0, !ok});
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_nst_eq_rden"}, n_nst_bad, 0);
    if (ok) begin
      check({tag, "_first_rd_lat"}, first_rd_cyc - t0, START_DLY + 1);
      check({tag, "_done_lat"}, done_cyc - t0, START_DLY + 1 + LAT + total);
      check({tag, "_busy_cycles"}, n_busy, START_DLY + LAT + total);
      check({tag, "_intt"}, {31'd0, ntt_intt}, {31'd0, intt});
      check({tag, "_intt_hold"}, n_intt_bad, 0);
    end else begin
      check({tag, "_busy_cycles"}, n_busy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {12'd0, busy, done, cfg_err, ntt_start, ntt_intt, read_en, wea,
                read_address, write_address}, 32'd0);
  endtask

  typedef struct {
    int bc;
    bit intt;
    bit ok;
    int total;
    string tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 1'b0, 1'b1, 16, "b1"};
    vecs[1] = '{4, 1'b1, 1'b1, 64, "b4"};
    vecs[2] = '{0, 1'b0, 1'b0, 0,  "b0_bad"};
    vecs[3] = '{5, 1'b1, 1'b0, 0,  "b5_bad"};
    vecs[4] = '{2, 1'b1, 1'b1, 32, "b2"};
    vecs[5] = '{3, 1'b0, 1'b1, 48, "b3"};

    clear_mon();
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();
    check_all_zero("idle_after_reset");

    foreach (vecs[i]) run_cfg(vecs[i].bc, vecs[i].intt, vecs[i].ok, vecs[i].total, vecs[i].tag);

    // Stray result after a completed batch must not be written.
    run_cfg(1, 1'b0, 1'b1, 16, "pre_extra");
    inject = 1'b1;
    #1;
    check("extra_valid_wea", {31'd0, wea}, 32'd0);
    check("extra_valid_waddr", {26'd0, write_address}, 32'd16);
    tick();
    inject = 1'b0;
    repeat (5) tick();
    check("extra_valid_writes", n_wr, 16);
    check("extra_valid_done", n_done, 1);

    // Reset in the middle of a batch-2 stream, then restart.
    begin
      bit hit = 0;
      clear_mon();
      batch_cnt = 3'd2; intt_in = 1'b1; cur_intt = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (read_en === 1'b1 && read_address == 6'd7) begin hit = 1; break; end
        tick();
      end
      check("abort_reached_read7", {31'd0, hit}, 32'd1);
      rst = 1'b1;
      tick();
      check_all_zero("abort_outputs");
      rst = 1'b0;
      repeat (3) tick();
      check("abort_no_done", n_done, 0);
      run_cfg(1, 1'b0, 1'b1, 16, "restart");
    end

    // start during STREAM and on the done cycle is ignored; intt_in changes mid-run.
    clear_mon();
    batch_cnt = 3'd2; intt_in = 1'b1; cur_intt = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (read_en === 1'b1 && read_address == 6'd5) break;
      tick();
    end
    batch_cnt = 3'd3; intt_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign");
    batch_cnt = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("ign_reads", n_rd, 32);
    check("ign_writes", n_wr, 32);
    check("ign_done_cnt", n_done, 1);
    check("ign_cfg_err", n_err, 0);
    check("ign_busy_after", {31'd0, busy}, 32'd0);
    check("ign_intt", {31'd0, ntt_intt}, 32'd1);
    check("ign_intt_hold", n_intt_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
